// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store engine. It takes the instruction held in the EXE/MEM
// register and performs one data-memory transaction. Requests go out over a
// valid/ready channel, and the reply comes back on a valid-only response
// channel. Load data is realigned to bit 0 and then sign- or zero-extended.
// Store data is shifted into its byte lanes with a matching byte mask.
// Misaligned accesses finish straight away with an exception and never touch
// memory. The pipeline is held through mem_stall_o until the access is done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_valid_i/re/we        instruction present / is a load / is a store
//   mem_funct3_i             size and sign (B,H,W,D,BU,HU,WU)
//   mem_addr_i, mem_wdata_i  effective address, store data (rs2)
//   except_in_i              instruction already faulted; no access
//   advance_i, flush_i       pipeline advance / kill the MEM instruction
//   dmem_req_*               request channel (8-byte aligned address)
//   dmem_resp_*              response / write acknowledge channel
//   load_data_o, done_o      extended load result, access complete
//   mem_stall_o              hold EXE/MEM and earlier stages
//   except_o/ecause_o/etval_o misalignment exception (4 load, 6 store)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              except_in_i,
    input  logic              advance_i,
    input  logic              flush_i,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_req_we_o,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [DATA_W-1:0] dmem_req_wdata_o,
    output logic [7:0]        dmem_req_wmask_o,
    input  logic              dmem_resp_valid_i,
    input  logic [DATA_W-1:0] dmem_resp_rdata_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic              done_o,
    output logic              mem_stall_o,
    output logic              except_o,
    output logic [63:0]       ecause_o,
    output logic [63:0]       etval_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              except_q, except_d;
    logic [63:0]       ecause_q, ecause_d;
    logic [63:0]       etval_q, etval_d;

    logic              start;
    logic [2:0]        align_mask;
    logic              misaligned;
    logic [7:0]        base_mask;
    logic [DATA_W-1:0] load_shifted;
    logic [DATA_W-1:0] load_ext;

    assign start = (state_q == IDLE) & mem_valid_i & (mem_re_i | mem_we_i)
                   & ~except_in_i & ~flush_i;

    // The low address bits that must be zero for the requested access size.
    always_comb begin
        align_mask = 3'b000;
        case (mem_funct3_i[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign misaligned = |(mem_addr_i[2:0] & align_mask);

    // Byte lanes touched by the latched access, before lane shifting.
    always_comb begin
        base_mask = 8'h00;
        case (funct3_q[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Bring the addressed bytes down to bit 0, then extend them.
    // Funct3 011 and 111 both return the full doubleword.
    always_comb begin
        load_shifted = dmem_resp_rdata_i >> {addr_q[2:0], 3'b000};
        load_ext     = load_shifted;
        case (funct3_q)
            3'b000:  load_ext = {{56{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_ext = {{48{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_ext = {{32{load_shifted[31]}}, load_shifted[31:0]};
            3'b100:  load_ext = {56'b0, load_shifted[7:0]};
            3'b101:  load_ext = {48'b0, load_shifted[15:0]};
            3'b110:  load_ext = {32'b0, load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // Next-state logic. A kill raised in REQ/RESP lets the transaction run to
    // completion so that the memory sees a clean request/response pair. Only
    // the result is dropped.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        load_data_d = load_data_q;
        except_d    = except_q;
        ecause_d    = ecause_q;
        etval_d     = etval_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (start) begin
                    addr_d      = mem_addr_i;
                    wdata_d     = mem_wdata_i;
                    funct3_d    = mem_funct3_i;
                    we_d        = mem_we_i;
                    load_data_d = '0;
                    if (misaligned) begin
                        state_d  = DONE;
                        except_d = 1'b1;
                        ecause_d = mem_we_i ? 64'd6 : 64'd4;
                        etval_d  = 64'(mem_addr_i);
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_i) kill_d = 1'b1;
                if (dmem_req_ready_i) state_d = RESP;
            end
            RESP: begin
                if (flush_i) kill_d = 1'b1;
                if (dmem_resp_valid_i) begin
                    if (kill_q | flush_i) begin
                        state_d = IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d     = DONE;
                        load_data_d = we_q ? '0 : load_ext;
                    end
                end
            end
            DONE: begin
                if (flush_i | advance_i) begin
                    state_d  = IDLE;
                    except_d = 1'b0;
                    ecause_d = '0;
                    etval_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            load_data_q <= '0;
            except_q    <= 1'b0;
            ecause_q    <= '0;
            etval_q     <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            load_data_q <= load_data_d;
            except_q    <= except_d;
            ecause_q    <= ecause_d;
            etval_q     <= etval_d;
        end
    end

    // Request fields come only from latched state. This keeps them stable
    // while the memory applies backpressure.
    assign dmem_req_valid_o = (state_q == REQ);
    assign dmem_req_we_o    = we_q;
    assign dmem_req_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
    assign dmem_req_wdata_o = wdata_q << {addr_q[2:0], 3'b000};
    assign dmem_req_wmask_o = we_q ? (base_mask << addr_q[2:0]) : 8'h00;

    assign load_data_o = load_data_q;
    assign done_o      = (state_q == DONE);
    assign mem_stall_o = start | (state_q == REQ) | (state_q == RESP);
    assign except_o    = except_q;
    assign ecause_o    = ecause_q;
    assign etval_o     = etval_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. Stimulus pushes the expected request and
// completion into scoreboard queues. A monitor compares them against whatever
// the DUT presents on the request channel and on done_o. A simple memory model
// answers requests using configurable ready and response delays.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic        mem_re_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [2:0]  mem_funct3_i = 3'b0;
    logic [63:0] mem_addr_i = '0;
    logic [63:0] mem_wdata_i = '0;
    logic        except_in_i = 1'b0;
    logic        advance_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic        dmem_req_we_o;
    logic [63:0] dmem_req_addr_o;
    logic [63:0] dmem_req_wdata_o;
    logic [7:0]  dmem_req_wmask_o;
    logic        dmem_resp_valid_i;
    logic [63:0] dmem_resp_rdata_i;
    logic [63:0] load_data_o;
    logic        done_o;
    logic        mem_stall_o;
    logic        except_o;
    logic [63:0] ecause_o;
    logic [63:0] etval_o;

    mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .mem_funct3_i(mem_funct3_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .except_in_i(except_in_i),
        .advance_i(advance_i), .flush_i(flush_i),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_req_we_o(dmem_req_we_o), .dmem_req_addr_o(dmem_req_addr_o),
        .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_req_wmask_o(dmem_req_wmask_o),
        .dmem_resp_valid_i(dmem_resp_valid_i), .dmem_resp_rdata_i(dmem_resp_rdata_i),
        .load_data_o(load_data_o), .done_o(done_o), .mem_stall_o(mem_stall_o),
        .except_o(except_o), .ecause_o(ecause_o), .etval_o(etval_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        exc;
        logic [63:0] cause;
        logic [63:0] tval;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int ready_wait = 0;
    int resp_wait = 1;
    logic [63:0] mem_word = 64'h8877665544332211;
    logic done_prev = 1'b0;

    // All inputs change 1 time unit after the rising edge. Outputs are read on
    // the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    task automatic expectReq(input logic [63:0] addr, input logic we,
                             input logic [63:0] wdata, input logic [7:0] wmask);
        req_t r;
        r.addr = addr; r.we = we; r.wdata = wdata; r.wmask = wmask;
        req_q.push_back(r);
    endtask

    task automatic expectResp(input logic [63:0] data, input logic exc,
                              input logic [63:0] cause, input logic [63:0] tval);
        resp_t r;
        r.data = data; r.exc = exc; r.cause = cause; r.tval = tval;
        resp_q.push_back(r);
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        mem_valid_i  = 1'b1;
        mem_re_i     = re;
        mem_we_i     = we;
        mem_funct3_i = f3;
        mem_addr_i   = addr;
        mem_wdata_i  = wdata;
    endtask

    task automatic clearStimulus();
        mem_valid_i  = 1'b0;
        mem_re_i     = 1'b0;
        mem_we_i     = 1'b0;
        mem_funct3_i = 3'b0;
        mem_addr_i   = '0;
        mem_wdata_i  = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_valid"}, dmem_req_valid_o, 0);
        checkOutput({tag, "_req_we"},    dmem_req_we_o, 0);
        checkOutput({tag, "_req_addr"},  dmem_req_addr_o, 0);
        checkOutput({tag, "_req_wdata"}, dmem_req_wdata_o, 0);
        checkOutput({tag, "_req_wmask"}, dmem_req_wmask_o, 0);
        checkOutput({tag, "_load_data"}, load_data_o, 0);
        checkOutput({tag, "_done"},      done_o, 0);
        checkOutput({tag, "_stall"},     mem_stall_o, 0);
        checkOutput({tag, "_except"},    except_o, 0);
        checkOutput({tag, "_ecause"},    ecause_o, 0);
        checkOutput({tag, "_etval"},     etval_o, 0);
    endtask

    // This runs one access from issue to retirement. Stall must be high until
    // done_o appears and low once it does. done_o must appear after exp_lat
    // falling edges. advance_i is held back for adv_delay cycles, and the
    // result must hold during that time.
    task automatic runAccess(input logic re, input logic we, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input int exp_lat, input int adv_delay,
                             input logic [63:0] exp_data);
        int cnt;
        tick();
        applyStimulus(re, we, f3, addr, wdata);
        @(negedge clk);
        checkOutput("stall_on_start", mem_stall_o, 1);
        tick();
        clearStimulus();
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (done_o) break;
            checkOutput("stall_busy", mem_stall_o, 1);
        end
        if (!done_o) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_timeout: got done_o=0 after %0d cycles, expected 1", cnt);
        end else begin
            checkOutput("latency", 64'(cnt), 64'(exp_lat));
            checkOutput("stall_in_done", mem_stall_o, 0);
        end
        for (int i = 0; i < adv_delay; i++) begin
            tick();
            @(negedge clk);
            checkOutput("done_hold", done_o, 1);
            checkOutput("data_hold", load_data_o, exp_data);
        end
        tick();
        advance_i = 1'b1;
        tick();
        advance_i = 1'b0;
        @(negedge clk);
        checkOutput("done_clear", done_o, 0);
        checkOutput("except_clear", except_o, 0);
    endtask

    // Memory model. On seeing a request it waits ready_wait cycles and then
    // raises ready for one cycle. It returns the response resp_wait cycles
    // after the request is accepted.
    initial begin
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b0;
        dmem_resp_rdata_i = '0;
        forever begin
            tick();
            if (dmem_req_valid_o && !rst) begin
                repeat (ready_wait) tick();
                dmem_req_ready_i = 1'b1;
                tick();
                dmem_req_ready_i = 1'b0;
                repeat (resp_wait - 1) tick();
                dmem_resp_valid_i = 1'b1;
                dmem_resp_rdata_i = mem_word;
                tick();
                dmem_resp_valid_i = 1'b0;
                dmem_resp_rdata_i = '0;
            end
        end
    end

    // Scoreboard monitor. Request fields are compared on every cycle that
    // valid is high, which also checks that they stay stable under
    // backpressure. Completions are checked on the rising edge of done_o.
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (dmem_req_valid_o) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_req: got req to 0x%016h, expected none", dmem_req_addr_o);
                end else begin
                    checkOutput("req_addr",  dmem_req_addr_o,  req_q[0].addr);
                    checkOutput("req_we",    dmem_req_we_o,    req_q[0].we);
                    checkOutput("req_wdata", dmem_req_wdata_o, req_q[0].wdata);
                    checkOutput("req_wmask", dmem_req_wmask_o, req_q[0].wmask);
                    if (dmem_req_ready_i) void'(req_q.pop_front());
                end
            end
            if (done_o && !done_prev) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got done_o=1, expected no completion");
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    checkOutput("load_data", load_data_o, e.data);
                    checkOutput("except",    except_o,    e.exc);
                    checkOutput("ecause",    ecause_o,    e.cause);
                    checkOutput("etval",     etval_o,     e.tval);
                end
            end
            done_prev = done_o;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        checkResetOutputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Load sizes and extension. Memory returns 0x8877665544332211.
        expectReq(64'h1000, 0, 0, 0); expectResp(64'h44, 0, 0, 0);
        runAccess(1, 0, 3'b100, 64'h1003, 0, 3, 0, 64'h44);
        expectReq(64'h1000, 0, 0, 0); expectResp(64'hFFFFFFFFFFFFFF88, 0, 0, 0);
        runAccess(1, 0, 3'b000, 64'h1007, 0, 3, 0, 64'hFFFFFFFFFFFFFF88);
        expectReq(64'h1000, 0, 0, 0); expectResp(64'hFFFFFFFF88776655, 0, 0, 0);
        runAccess(1, 0, 3'b010, 64'h1004, 0, 3, 0, 64'hFFFFFFFF88776655);
        expectReq(64'h1000, 0, 0, 0); expectResp(64'h0000000088776655, 0, 0, 0);
        runAccess(1, 0, 3'b110, 64'h1004, 0, 3, 0, 64'h0000000088776655);
        expectReq(64'h1000, 0, 0, 0); expectResp(64'h4433, 0, 0, 0);
        runAccess(1, 0, 3'b101, 64'h1002, 0, 3, 0, 64'h4433);

        // Store lanes.
        expectReq(64'h2000, 1, 64'hABCD000000000000, 8'hC0); expectResp(0, 0, 0, 0);
        runAccess(0, 1, 3'b001, 64'h2006, 64'hABCD, 3, 0, 0);
        expectReq(64'h2000, 1, 64'h5A00, 8'h02); expectResp(0, 0, 0, 0);
        runAccess(0, 1, 3'b000, 64'h2001, 64'h5A, 3, 0, 0);

        // Misaligned accesses complete without a memory request.
        expectResp(0, 1, 64'd4, 64'h1002);
        runAccess(1, 0, 3'b010, 64'h1002, 0, 1, 0, 0);
        expectResp(0, 1, 64'd6, 64'h3004);
        runAccess(0, 1, 3'b011, 64'h3004, 64'h1234, 1, 0, 0);

        // An instruction that already faulted performs no access.
        tick();
        applyStimulus(1, 0, 3'b011, 64'h4000, 0);
        except_in_i = 1'b1;
        @(negedge clk);
        checkOutput("except_in_stall", mem_stall_o, 0);
        tick();
        clearStimulus();
        except_in_i = 1'b0;
        @(negedge clk);
        checkOutput("except_in_req", dmem_req_valid_o, 0);
        checkOutput("except_in_done", done_o, 0);

        // Backpressure: ready is low for 3 cycles and the response comes 5
        // cycles after acceptance. advance_i is held back for 2 cycles.
        ready_wait = 3; resp_wait = 5;
        expectReq(64'h1008, 0, 0, 0); expectResp(64'h8877665544332211, 0, 0, 0);
        runAccess(1, 0, 3'b011, 64'h1008, 0, 10, 2, 64'h8877665544332211);
        ready_wait = 0; resp_wait = 1;

        // Flush while in RESP. Stall stays high until the response arrives,
        // there is no completion, and the unit returns to IDLE.
        resp_wait = 4;
        expectReq(64'h1000, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 3'b011, 64'h1000, 0);
        @(negedge clk);
        tick();
        clearStimulus();
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        checkOutput("flush_resp_stall", mem_stall_o, 1);
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush_resp_stall", mem_stall_o, 1);
            checkOutput("flush_resp_done", done_o, 0);
        end
        @(negedge clk);
        checkOutput("flush_resp_idle_stall", mem_stall_o, 0);
        checkOutput("flush_resp_idle_done", done_o, 0);
        resp_wait = 1;
        expectReq(64'h4000, 0, 0, 0); expectResp(64'h8877665544332211, 0, 0, 0);
        runAccess(1, 0, 3'b011, 64'h4000, 0, 3, 0, 64'h8877665544332211);

        // Flush while in REQ with ready low. The request is never withdrawn.
        ready_wait = 4;
        expectReq(64'h1010, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 3'b011, 64'h1010, 0);
        @(negedge clk);
        tick();
        clearStimulus();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("flush_req_valid_held", dmem_req_valid_o, 1);
        end
        @(negedge clk);
        checkOutput("flush_req_after_accept", dmem_req_valid_o, 0);
        checkOutput("flush_req_resp_stall", mem_stall_o, 1);
        @(negedge clk);
        checkOutput("flush_req_idle_stall", mem_stall_o, 0);
        checkOutput("flush_req_idle_done", done_o, 0);
        ready_wait = 0;

        // Reset in the middle of REQ. A following load must start cleanly.
        ready_wait = 6;
        expectReq(64'h1018, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 3'b011, 64'h1018, 0);
        @(negedge clk);
        tick();
        clearStimulus();
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        req_q.delete();
        @(negedge clk);
        checkResetOutputs("midreq_reset");
        repeat (10) tick();
        ready_wait = 0;
        expectReq(64'h1000, 0, 0, 0); expectResp(64'h8877665544332211, 0, 0, 0);
        runAccess(1, 0, 3'b011, 64'h1000, 0, 3, 0, 64'h8877665544332211);

        repeat (3) tick();
        checkOutput("req_queue_drained",  64'(req_q.size()), 0);
        checkOutput("resp_queue_drained", 64'(resp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
